// File: rtl/data_mem.sv
// data_mem: data-side memory responder for the single-cycle RV32I core.
// Byte-lane stores on the clock edge, combinational width-aligned and
// sign/zero-extended loads, sticky fault flag.
// Optional feature macro: DATA_MEM_MMIO_EN adds the MMIO window at
// 0xFFFF_FF00..0xFFFF_FF0F (cycle_lo, cycle_hi, tohost, status).
module data_mem #(
  parameter int    DEPTH_WORDS = 1024,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  width,
  input  logic        ld_unsigned,
  input  logic        write_mem,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        halt,
  output logic [31:0] exit_code
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {
    W_BYTE = 2'b00,
    W_HALF = 2'b01,
    W_WORD = 2'b10,
    W_ILL  = 2'b11
  } width_e;

  width_e        w;
  logic          align_ok;
  logic          in_ram;
  logic          ram_ok;
  logic          mmio_ok;
  logic          bad;
  logic          fault_clr;
  logic [31:0]   mmio_rdata;
  logic [AW-1:0] word_idx;
  logic [31:0]   ram_word;
  logic [31:0]   lane_data;
  logic [31:0]   ram_rdata;
  logic [3:0]    byte_en;
  logic [31:0]   wdata_lanes;
  logic          ram_we;

  logic [31:0] mem [DEPTH_WORDS];

  assign w        = width_e'(width);
  assign in_ram   = ({1'b0, addr} < RAM_BYTES);
  assign word_idx = addr[AW+1:2];
  assign ram_ok   = in_ram && align_ok;
  // Anything that is neither a legal RAM access nor a legal MMIO access faults.
  assign bad      = !(ram_ok || mmio_ok);

  // Alignment rule for the requested access size.
  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    align_ok = 1'b0;
    case (w)
      W_BYTE:  align_ok = 1'b1;
      W_HALF:  align_ok = (addr[0] == 1'b0);
      W_WORD:  align_ok = (addr[1:0] == 2'b00);
      default: align_ok = 1'b0;
    endcase
  end

  // RAM load path: pick the word, shift the addressed lane to bit 0, extend.
  assign ram_word  = mem[word_idx];
  assign lane_data = ram_word >> {addr[1:0], 3'b000};

  always_comb begin
    ram_rdata = lane_data;
    case (w)
      W_BYTE:  ram_rdata = {{24{~ld_unsigned & lane_data[7]}}, lane_data[7:0]};
      W_HALF:  ram_rdata = {{16{~ld_unsigned & lane_data[15]}}, lane_data[15:0]};
      default: ram_rdata = lane_data;
    endcase
  end

  // Store lane enables and store data replicated onto every candidate lane.
  always_comb begin
    byte_en     = 4'b0000;
    wdata_lanes = wdata;
    case (w)
      W_BYTE: begin
        byte_en     = 4'b0001 << addr[1:0];
        wdata_lanes = {4{wdata[7:0]}};
      end
      W_HALF: begin
        byte_en     = addr[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata[15:0]}};
      end
      W_WORD:  byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  // A store with reset high at the edge is dropped.
  assign ram_we = write_mem && ram_ok && !rst;

  // RAM write port, byte-lane granular.
  // NOTE: the RAM array is deliberately not reset; it keeps its image or prior writes across rst.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
      end
    end
  end

`ifdef DATA_MEM_MMIO_EN

  typedef enum logic [1:0] {
    R_CYCLE_LO = 2'd0,
    R_CYCLE_HI = 2'd1,
    R_TOHOST   = 2'd2,
    R_STATUS   = 2'd3
  } mmio_reg_e;

  logic        in_mmio;
  logic        mmio_wr;
  mmio_reg_e   reg_sel;
  logic [63:0] cycle_cnt;

  // MMIO registers accept only aligned word accesses.
  assign in_mmio   = (addr[31:4] == 28'hFFF_FFF0);
  assign mmio_ok   = in_mmio && (w == W_WORD) && (addr[1:0] == 2'b00);
  assign reg_sel   = mmio_reg_e'(addr[3:2]);
  assign mmio_wr   = write_mem && mmio_ok;
  assign fault_clr = mmio_wr && (reg_sel == R_STATUS) && wdata[0];

  // Free-running 64-bit cycle counter; wraps naturally.
  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cycle_cnt <= '0;
    else     cycle_cnt <= cycle_cnt + 64'd1;
  end

  // tohost: first write latches exit_code and raises halt; later writes ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt      <= 1'b0;
      exit_code <= '0;
    end else if (mmio_wr && (reg_sel == R_TOHOST) && !halt) begin
      halt      <= 1'b1;
      exit_code <= wdata;
    end
  end

  // MMIO read mux.
  always_comb begin
    mmio_rdata = '0;
    case (reg_sel)
      R_CYCLE_LO: mmio_rdata = cycle_cnt[31:0];
      R_CYCLE_HI: mmio_rdata = cycle_cnt[63:32];
      R_TOHOST:   mmio_rdata = exit_code;
      R_STATUS:   mmio_rdata = {30'd0, halt, fault};
      default:    mmio_rdata = '0;
    endcase
  end

`else

  // Without the MMIO window the high addresses are simply out of range.
  assign mmio_ok    = 1'b0;
  assign fault_clr  = 1'b0;
  assign mmio_rdata = '0;
  assign halt       = 1'b0;
  assign exit_code  = '0;

`endif

  // Load result: RAM, MMIO, or zero for any illegal/out-of-range access.
  always_comb begin
    rdata = '0;
    if (ram_ok)       rdata = ram_rdata;
    else if (mmio_ok) rdata = mmio_rdata;
  end

  // Sticky fault flag; a new fault wins over a W1C clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            fault <= 1'b0;
    else if (bad)       fault <= 1'b1;
    else if (fault_clr) fault <= 1'b0;
  end

endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: self-checking bench for data_mem. Directed table vectors,
// hand sequences for reset/MMIO corners, and random RAM traffic checked
// against a byte-array reference model.
module tb_data_mem;

  localparam int DEPTH     = 1024;
  localparam int RAM_BYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [1:0]  width = 2'b10;
  logic        ld_unsigned = 1'b0;
  logic        write_mem = 1'b0;
  logic [31:0] rdata;
  logic        fault;
  logic        halt;
  logic [31:0] exit_code;

  int tests = 0;
  int fails = 0;

  logic [7:0] mbytes [RAM_BYTES];
  bit         model_fault = 1'b0;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] wd;
    logic [1:0]  w;
    bit          u;
    bit          wr;
    bit          chk;
    logic [31:0] exp_rd;
    bit          exp_fault;
  } vec_t;

  vec_t vecs[$];

  data_mem #(.DEPTH_WORDS(DEPTH), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .width(width),
    .ld_unsigned(ld_unsigned), .write_mem(write_mem), .rdata(rdata),
    .fault(fault), .halt(halt), .exit_code(exit_code)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: RAM as a flat little-endian byte array.
  function automatic bit m_legal(input logic [31:0] a, input logic [1:0] w);
    int unsigned sz;
    if (w == 2'b11) return 1'b0;
    sz = 1 << w;
    return ((a % sz) == 0) && (a < 32'(RAM_BYTES));
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic [1:0] w, input bit u);
    longint unsigned v;
    int n;
    v = 0;
    if (!m_legal(a, w)) return 32'd0;
    n = 1 << w;
    for (int i = 0; i < n; i++) v += longint'(mbytes[a + i]) << (8 * i);
    if (!u && n < 4 && v >= (64'd1 << (8 * n - 1))) v = v + 64'h1_0000_0000 - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  function automatic void m_write(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] w);
    int n;
    if (!m_legal(a, w)) return;
    n = 1 << w;
    for (int i = 0; i < n; i++) mbytes[a + i] = wd[8*i +: 8];
  endfunction

  function automatic void add(input string name, input logic [31:0] a, input logic [31:0] wd,
                              input logic [1:0] w, input bit u, input bit wr, input bit chk,
                              input logic [31:0] exp_rd, input bit exp_fault);
    vec_t v;
    v.name = name; v.a = a; v.wd = wd; v.w = w; v.u = u; v.wr = wr;
    v.chk = chk; v.exp_rd = exp_rd; v.exp_fault = exp_fault;
    vecs.push_back(v);
  endfunction

  // One access cycle: called at posedge+1, checks rdata mid-cycle, returns at next posedge+1.
  task automatic access(input string name, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] w, input bit u, input bit wr, input bit chk,
                        input logic [31:0] exp);
    addr = a; wdata = wd; width = w; ld_unsigned = u; write_mem = wr;
    #3;
    if (chk) check({name, " rdata"}, rdata, exp);
    @(posedge clk); #1;
    addr = '0; wdata = '0; width = 2'b10; ld_unsigned = 1'b0; write_mem = 1'b0;
  endtask

  // Asynchronous reset pulse between edges; registers must clear at once.
  task automatic reset_pulse(input string name);
    #2 rst = 1'b1;
    #1;
    check({name, " fault"}, {31'd0, fault}, 32'd0);
    check({name, " halt"}, {31'd0, halt}, 32'd0);
    check({name, " exit_code"}, exit_code, 32'd0);
    rst = 1'b0;
    model_fault = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    // Directed vectors; expected values worked out by hand.
    add("SW 0x10",          32'h10, 32'h8000_00FF, 2'b10, 0, 1, 0, 32'h0,         0);
    add("LB 0x10",          32'h10, 32'h0,         2'b00, 0, 0, 1, 32'hFFFF_FFFF, 0);
    add("LBU 0x13",         32'h13, 32'h0,         2'b00, 1, 0, 1, 32'h0000_0080, 0);
    add("LH 0x12",          32'h12, 32'h0,         2'b01, 0, 0, 1, 32'hFFFF_8000, 0);
    add("LHU 0x12",         32'h12, 32'h0,         2'b01, 1, 0, 1, 32'h0000_8000, 0);
    add("LW 0x10",          32'h10, 32'h0,         2'b10, 0, 0, 1, 32'h8000_00FF, 0);
    add("LBU 0x10",         32'h10, 32'h0,         2'b00, 1, 0, 1, 32'h0000_00FF, 0);
    add("SW 0x20",          32'h20, 32'h1122_3344, 2'b10, 0, 1, 0, 32'h0,         0);
    add("SB 0x21",          32'h21, 32'h1234_56AA, 2'b00, 0, 1, 0, 32'h0,         0);
    add("LW 0x20 after SB", 32'h20, 32'h0,         2'b10, 0, 0, 1, 32'h1122_AA44, 0);
    add("SH 0x22",          32'h22, 32'hBEEF_5566, 2'b01, 0, 1, 0, 32'h0,         0);
    add("LW 0x20 after SH", 32'h20, 32'h0,         2'b10, 1, 0, 1, 32'h5566_AA44, 0);
    add("LH 0x20",          32'h20, 32'h0,         2'b01, 0, 0, 1, 32'hFFFF_AA44, 0);
    add("LB 0x23",          32'h23, 32'h0,         2'b00, 0, 0, 1, 32'h0000_0055, 0);
    add("LB 0x21",          32'h21, 32'h0,         2'b00, 0, 0, 1, 32'hFFFF_FFAA, 0);
    add("LBU 0x21",         32'h21, 32'h0,         2'b00, 1, 0, 1, 32'h0000_00AA, 0);
    add("SW 0x22 misalign", 32'h22, 32'hDEAD_BEEF, 2'b10, 0, 1, 1, 32'h0,         1);
    add("LW 0x20 kept",     32'h20, 32'h0,         2'b10, 0, 0, 1, 32'h5566_AA44, 1);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset fault", {31'd0, fault}, 32'd0);
    check("reset halt", {31'd0, halt}, 32'd0);
    check("reset exit_code", exit_code, 32'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      access(vecs[i].name, vecs[i].a, vecs[i].wd, vecs[i].w, vecs[i].u, vecs[i].wr,
             vecs[i].chk, vecs[i].exp_rd);
      check({vecs[i].name, " fault"}, {31'd0, fault}, {31'd0, vecs[i].exp_fault});
    end

`ifdef DATA_MEM_MMIO_EN
    // W1C of fault through status, then illegal-width MMIO access.
    access("W1C status", 32'hFFFF_FF0C, 32'h1, 2'b10, 0, 1, 0, 32'h0);
    check("W1C fault", {31'd0, fault}, 32'd0);
    access("LB status", 32'hFFFF_FF0C, 32'h0, 2'b00, 0, 0, 1, 32'h0);
    check("LB status fault", {31'd0, fault}, 32'd1);
    access("LW status", 32'hFFFF_FF0C, 32'h0, 2'b10, 0, 0, 1, 32'h1);
    access("W1C again", 32'hFFFF_FF0C, 32'h1, 2'b10, 0, 1, 0, 32'h0);
    check("W1C again fault", {31'd0, fault}, 32'd0);
    access("SW cycle_lo RO", 32'hFFFF_FF00, 32'h123, 2'b10, 0, 1, 0, 32'h0);
    check("RO write no fault", {31'd0, fault}, 32'd0);
`endif

    // Out-of-range and illegal accesses, each from a clean fault flag.
    reset_pulse("rst before OOR");
    access("LW OOR", 32'(RAM_BYTES), 32'h0, 2'b10, 0, 0, 1, 32'h0);
    check("LW OOR fault", {31'd0, fault}, 32'd1);
    reset_pulse("rst after OOR");
    access("width 11", 32'h20, 32'h0, 2'b11, 0, 0, 1, 32'h0);
    check("width 11 fault", {31'd0, fault}, 32'd1);
    reset_pulse("rst after width11");
    access("SW OOR", 32'(RAM_BYTES + 4), 32'h5555_5555, 2'b10, 0, 1, 0, 32'h0);
    check("SW OOR fault", {31'd0, fault}, 32'd1);
    reset_pulse("rst after SW OOR");
    access("LH 0x11 misalign", 32'h11, 32'h0, 2'b01, 0, 0, 1, 32'h0);
    check("LH misalign fault", {31'd0, fault}, 32'd1);

    // Reset asserted during a store: flags clear at once, the store is dropped.
    addr = 32'h20; wdata = 32'hDEAD_BEEF; width = 2'b10; write_mem = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("async rst fault", {31'd0, fault}, 32'd0);
    check("async rst halt", {31'd0, halt}, 32'd0);
    check("async rst exit_code", exit_code, 32'd0);
    @(posedge clk); #3;
    write_mem = 1'b0; addr = '0;
    rst = 1'b0;
    // Counter is 0 in this cycle; 10 edges later it reads 10.
    repeat (10) @(posedge clk);
    #1;
`ifdef DATA_MEM_MMIO_EN
    access("LW cycle_lo", 32'hFFFF_FF00, 32'h0, 2'b10, 0, 0, 1, 32'd10);
    access("LW cycle_hi", 32'hFFFF_FF04, 32'h0, 2'b10, 0, 0, 1, 32'd0);
    access("LW 0x20 after rst", 32'h20, 32'h0, 2'b10, 0, 0, 1, 32'h5566_AA44);
    access("SW tohost 1", 32'hFFFF_FF08, 32'h1, 2'b10, 0, 1, 0, 32'h0);
    check("halt set", {31'd0, halt}, 32'd1);
    check("exit_code 1", exit_code, 32'd1);
    access("SW tohost 5", 32'hFFFF_FF08, 32'h5, 2'b10, 0, 1, 0, 32'h0);
    check("exit_code frozen", exit_code, 32'd1);
    access("LW tohost", 32'hFFFF_FF08, 32'h0, 2'b10, 0, 0, 1, 32'd1);
    access("LW status halted", 32'hFFFF_FF0C, 32'h0, 2'b10, 0, 0, 1, 32'd2);
    access("SB after halt", 32'h20, 32'h77, 2'b00, 0, 1, 0, 32'h0);
    access("LW 0x20 after halt", 32'h20, 32'h0, 2'b10, 0, 0, 1, 32'h5566_AA77);
    check("no fault mmio", {31'd0, fault}, 32'd0);
    addr = 32'hFFFF_FF00;
    #2 rst = 1'b1;
    #1;
    check("rst counter", rdata, 32'd0);
    check("rst halt", {31'd0, halt}, 32'd0);
    check("rst exit_code", exit_code, 32'd0);
    rst = 1'b0; addr = '0;
    @(posedge clk); #1;
`else
    access("LW 0x20 after rst", 32'h20, 32'h0, 2'b10, 0, 0, 1, 32'h5566_AA44);
    check("no fault after rst", {31'd0, fault}, 32'd0);
    access("LW cycle_lo off", 32'hFFFF_FF00, 32'h0, 2'b10, 0, 0, 1, 32'd0);
    check("MMIO off fault", {31'd0, fault}, 32'd1);
    access("SW tohost off", 32'hFFFF_FF08, 32'h1, 2'b10, 0, 1, 0, 32'h0);
    check("MMIO off halt", {31'd0, halt}, 32'd0);
    check("MMIO off exit_code", exit_code, 32'd0);
    check("MMIO off fault sticky", {31'd0, fault}, 32'd1);
`endif
    reset_pulse("rst before random");

    // Fill RAM with random words so the model knows every byte.
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] v;
      v = $urandom();
      access("init", 32'(i * 4), v, 2'b10, 0, 1, 0, 32'h0);
      m_write(32'(i * 4), v, 2'b10);
    end

    // Random traffic; reads during writes must see pre-edge contents.
    for (int k = 0; k < 1500; k++) begin
      int          sel;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] exp;
      logic [1:0]  w;
      bit          u;
      bit          wr;
      sel = $urandom_range(0, 19);
      w   = 2'($urandom_range(0, 2));
      if (sel == 0) w = 2'b11;
      if (sel == 1)      a = 32'h8000_0000 | 32'($urandom_range(0, 255));
      else if (sel == 2) a = 32'(RAM_BYTES + $urandom_range(0, 63));
      else               a = 32'($urandom_range(0, RAM_BYTES - 1));
      if (sel > 4 && w != 2'b11) a = a & ~((32'd1 << w) - 32'd1);
      u   = 1'($urandom_range(0, 1));
      wr  = ($urandom_range(0, 2) == 0);
      wd  = $urandom();
      exp = m_read(a, w, u);
      access("rand", a, wd, w, u, wr, 1, exp);
      if (m_legal(a, w)) begin
        if (wr) m_write(a, wd, w);
      end else begin
        model_fault = 1'b1;
      end
      check("rand fault", {31'd0, fault}, {31'd0, model_fault});
      if (model_fault) reset_pulse("rand rst");
    end

    // Final readback of a sample of words against the model.
    for (int i = 0; i < 16; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, DEPTH - 1) * 4);
      access("final LW", a, 32'h0, 2'b10, 0, 0, 1, m_read(a, 2'b10, 1'b0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
